// File: rtl/vga_scan_mixer_if.sv
// Scan-out bundle between the raster mixer (master) and the sprite renderers
// plus VGA pins (slave side).
interface vga_scan_mixer_if #(
    parameter int NLAYERS = 4
);
    logic [9:0]            vga_x;
    logic [9:0]            vga_y;
    logic [24*NLAYERS-1:0] layer_rgb;
    logic [NLAYERS-1:0]    layer_en;
    logic [7:0]            R;
    logic [7:0]            G;
    logic [7:0]            B;
    logic                  hsync;
    logic                  vsync;
    logic                  blank_n;
    logic                  pix_tick;
    logic                  frame_end;

    modport master (
        output vga_x, vga_y, R, G, B, hsync, vsync, blank_n, pix_tick, frame_end,
        input  layer_rgb, layer_en
    );

    modport slave (
        input  vga_x, vga_y, R, G, B, hsync, vsync, blank_n, pix_tick, frame_end,
        output layer_rgb, layer_en
    );
endinterface

// File: rtl/vga_scan_mixer.sv
// Raster scan generator with per-pixel layer sampling, fixed-priority
// compositing over a background, and sync/blank aligned to the mixed pixel.
module vga_scan_mixer #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          NLAYERS  = 4,
    parameter logic [23:0] BG_RGB   = 24'h000000,
    parameter int          CLK_DIV  = 2
) (
    input  logic             clk,
    input  logic             rst,
    vga_scan_mixer_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] V_PRE   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic [23:0]      r_rgb_p1;
    logic             r_hsync_p1;
    logic             r_vsync_p1;
    logic             r_blank_n_p1;
    logic             r_frame_end;

    logic             w_div_wrap;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic             w_h_wrap;
    logic [23:0]      w_mix;

    // Lowest-index enabled layer wins; background otherwise.
    function automatic logic [23:0] mix_pixel(input logic [24*NLAYERS-1:0] rgb,
                                              input logic [NLAYERS-1:0]    en);
        logic [23:0] c;
        c = BG_RGB;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (en[i]) c = rgb[24*i +: 24];
        end
        return c;
    endfunction

    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_h_wrap   = (r_h == H_LAST);
    assign w_active   = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs       = (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs       = (r_v >= VS_BEG) && (r_v < VS_END);
    assign w_mix      = mix_pixel(bus.layer_rgb, bus.layer_en);

    // The tick is registered from the divider wrap, so it first rises on the CLK_DIV-th edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_wrap ? '0 : r_div + 1'b1;
            r_tick <= w_div_wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_tick) begin
            r_h <= w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end
    end

    // Stage p1: pixel at the current scan coordinate, captured on the tick edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb_p1     <= '0;
            r_hsync_p1   <= 1'b1;
            r_vsync_p1   <= 1'b1;
            r_blank_n_p1 <= 1'b0;
            r_frame_end  <= 1'b0;
        end else begin
            if (r_tick) begin
                r_rgb_p1     <= w_active ? w_mix : 24'h000000;
                r_hsync_p1   <= ~w_hs;
                r_vsync_p1   <= ~w_vs;
                r_blank_n_p1 <= w_active;
            end
            r_frame_end <= r_tick && w_h_wrap && (r_v == V_PRE);
        end
    end

    assign bus.vga_x     = r_h;
    assign bus.vga_y     = r_v;
    assign bus.R         = r_rgb_p1[23:16];
    assign bus.G         = r_rgb_p1[15:8];
    assign bus.B         = r_rgb_p1[7:0];
    assign bus.hsync     = r_hsync_p1;
    assign bus.vsync     = r_vsync_p1;
    assign bus.blank_n   = r_blank_n_p1;
    assign bus.pix_tick  = r_tick;
    assign bus.frame_end = r_frame_end;
endmodule

// File: tb/tb_vga_scan_mixer.sv
// Bench for vga_scan_mixer: a CLK_DIV=2 and a CLK_DIV=1 build on a shrunken
// raster, both checked every clock against a pixel-index model.
module tb_vga_scan_mixer;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int NL  = 4;
    localparam logic [23:0] BG = 24'h123456;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic [24*NL-1:0] l_rgb = '0;
    logic [NL-1:0]   l_en  = '0;
    int              n_chk = 0;
    int              n_err = 0;

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int CD   = (k == 0) ? 2 : 1;
        localparam int FPER = (k == 0) ? 624 : 312;
        localparam int BLK  = (k == 0) ? 256 : 128;
        localparam int HSL  = (k == 0) ? 78 : 39;
        localparam int VSL  = (k == 0) ? 96 : 48;

        vga_scan_mixer_if #(.NLAYERS(NL)) bus ();
        assign bus.layer_rgb = l_rgb;
        assign bus.layer_en  = l_en;

        vga_scan_mixer #(
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
            .NLAYERS(NL), .BG_RGB(BG), .CLK_DIV(CD)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        // Model: e = edges since reset, a = pixels advanced; ph/pv/s_* = last sampled pixel.
        int               e  = 0;
        int               a  = 0;
        int               ph = 0;
        int               pv = 0;
        logic             lt = 1'b0;
        logic [24*NL-1:0] s_rgb = '0;
        logic [NL-1:0]    s_en  = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                e  <= 0;
                a  <= 0;
                lt <= 1'b0;
            end else begin
                e <= e + 1;
                if (e >= CD && (e % CD) == 0) begin
                    a     <= a + 1;
                    ph    <= a % HT;
                    pv    <= (a / HT) % VT;
                    s_rgb <= l_rgb;
                    s_en  <= l_en;
                    lt    <= 1'b1;
                end else begin
                    lt <= 1'b0;
                end
            end
        end

        int          fcnt, bl, hl, vl;
        logic        have;
        logic        act_px;
        logic [23:0] xc;
        logic [4:0]  xf;

        initial begin
            have = 1'b0; fcnt = 0; bl = 0; hl = 0; vl = 0;
            forever begin
                @(negedge clk);
                if (a == 0) begin
                    xc = '0;
                    xf = 5'b11000;
                end else begin
                    act_px = (ph < HA) && (pv < VA);
                    xc = '0;
                    if (act_px) begin
                        xc = BG;
                        for (int i = 0; i < NL; i++) begin
                            if (s_en[i]) begin
                                xc = s_rgb[24*i +: 24];
                                break;
                            end
                        end
                    end
                    xf[4] = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
                    xf[3] = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
                    xf[2] = act_px;
                    xf[0] = lt && (ph == HT - 1) && (pv == VA - 1);
                end
                xf[1] = (e >= CD) && ((e % CD) == 0);
                check($sformatf("i%0d_xy", k), {12'd0, bus.vga_y, bus.vga_x},
                      {12'd0, 10'((a / HT) % VT), 10'(a % HT)});
                check($sformatf("i%0d_rgb", k), {8'd0, bus.R, bus.G, bus.B}, {8'd0, xc});
                check($sformatf("i%0d_flags", k),
                      {27'd0, bus.hsync, bus.vsync, bus.blank_n, bus.pix_tick, bus.frame_end},
                      {27'd0, xf});
                if (rst) begin
                    have = 1'b0;
                end else begin
                    fcnt++;
                    bl += int'(bus.blank_n);
                    hl += int'(!bus.hsync);
                    vl += int'(!bus.vsync);
                    if (bus.frame_end) begin
                        if (have) begin
                            check($sformatf("i%0d_frame_period", k), fcnt, FPER);
                            check($sformatf("i%0d_blank_clocks", k), bl, BLK);
                            check($sformatf("i%0d_hsync_clocks", k), hl, HSL);
                            check($sformatf("i%0d_vsync_clocks", k), vl, VSL);
                        end
                        have = 1'b1; fcnt = 0; bl = 0; hl = 0; vl = 0;
                    end
                end
            end
        end
    end

    wire [23:0] rgb0 = {g_dut[0].bus.R, g_dut[0].bus.G, g_dut[0].bus.B};
    wire [23:0] rgb1 = {g_dut[1].bus.R, g_dut[1].bus.G, g_dut[1].bus.B};
    wire [19:0] xy0  = {g_dut[0].bus.vga_y, g_dut[0].bus.vga_x};
    wire [19:0] xy1  = {g_dut[1].bus.vga_y, g_dut[1].bus.vga_x};
    wire [4:0]  flg0 = {g_dut[0].bus.hsync, g_dut[0].bus.vsync, g_dut[0].bus.blank_n,
                        g_dut[0].bus.pix_tick, g_dut[0].bus.frame_end};
    wire [4:0]  flg1 = {g_dut[1].bus.hsync, g_dut[1].bus.vsync, g_dut[1].bus.blank_n,
                        g_dut[1].bus.pix_tick, g_dut[1].bus.frame_end};

    task automatic wait_pix(input int h, input int v);
        int  n;
        bit  hit;
        n = 0;
        hit = 0;
        while (!hit && n < 2000) begin
            @(negedge clk);
            n++;
            hit = ((g_dut[0].a % HT) == h) && (((g_dut[0].a / HT) % VT) == v);
        end
        if (!hit) check($sformatf("wait_pix_%0d_%0d_timeout", h, v), 32'd0, 32'd1);
    endtask

    task automatic rand_layers();
        l_rgb = {$urandom, $urandom, $urandom};
        l_en  = ($urandom_range(0, 4) == 0) ? '0 : NL'($urandom);
    endtask

    task automatic random_run(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #2;
            rand_layers();
            @(negedge clk); #2;
            if ($urandom_range(0, 1) == 1) rand_layers();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_xy0"}, {12'd0, xy0}, 32'd0);
        check({tag, "_rgb0"}, {8'd0, rgb0}, 32'd0);
        check({tag, "_flg0"}, {27'd0, flg0}, 32'h18);
        check({tag, "_xy1"}, {12'd0, xy1}, 32'd0);
        check({tag, "_rgb1"}, {8'd0, rgb1}, 32'd0);
        check({tag, "_flg1"}, {27'd0, flg1}, 32'h18);
    endtask

    task automatic check_release();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("tick0_edge%0d", i), {31'd0, g_dut[0].bus.pix_tick}, {31'd0, (i % 2) == 0});
            check($sformatf("tick1_edge%0d", i), {31'd0, g_dut[1].bus.pix_tick}, 32'd1);
            if (i == 2) check("restart_x_held", {12'd0, xy0}, 32'd0);
            if (i == 3) check("restart_x_first", {12'd0, xy0}, 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("por");
        #2 rst = 1'b0;
        check_release();

        random_run(2000);

        // Priority at (5,3): layers 1 and 2 enabled, layer 1 must win.
        wait_pix(5, 3);
        l_rgb = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h777777};
        l_en  = 4'b0110;
        wait_pix(6, 3);
        check("prio_l1", {8'd0, rgb0}, 32'h00FF0000);
        check("prio_blank_n", {31'd0, g_dut[0].bus.blank_n}, 32'd1);
        l_en = 4'b0000;
        wait_pix(7, 3);
        check("prio_bg", {8'd0, rgb0}, 32'h00123456);
        l_en = 4'b1000;
        wait_pix(8, 3);
        check("prio_l3", {8'd0, rgb0}, 32'h000000FF);

        // Mid-pixel changes of layer_en: only the value at the tick edge counts.
        l_rgb[23:0] = 24'hAABBCC;
        l_en = 4'b0000;
        @(posedge clk); #2;
        l_en = 4'b0001;
        @(posedge clk); #2;
        l_en = 4'b0001;
        @(negedge clk);
        check("toggle_hi", {8'd0, rgb0}, 32'h00AABBCC);
        @(posedge clk); #2;
        l_en = 4'b0000;
        @(posedge clk); #2;
        @(negedge clk);
        check("toggle_lo", {8'd0, rgb0}, 32'h00123456);

        // Horizontal blanking inside the sync pulse.
        wait_pix(18, 3);
        l_rgb = {24'h0A0B0C, 24'h112233, 24'h445566, 24'h778899};
        l_en  = 4'hF;
        wait_pix(19, 3);
        check("hblank_rgb", {8'd0, rgb0}, 32'd0);
        check("hblank_sync", {29'd0, flg0[4:2]}, 32'b010);

        // Entering vertical blanking: one-clock frame_end.
        wait_pix(0, 8);
        check("wrap_vblank_xy", {12'd0, xy0}, {12'd0, 10'd8, 10'd0});
        check("fe_pulse", {31'd0, g_dut[0].bus.frame_end}, 32'd1);
        @(negedge clk);
        check("fe_one_clock", {31'd0, g_dut[0].bus.frame_end}, 32'd0);

        wait_pix(4, 9);
        l_en = 4'hF;
        wait_pix(5, 9);
        check("vblank_rgb", {8'd0, rgb0}, 32'd0);
        check("vblank_sync", {29'd0, flg0[4:2]}, 32'b100);

        wait_pix(0, 0);
        check("wrap_frame_xy", {12'd0, xy0}, 32'd0);
        check("wrap_no_fe", {31'd0, g_dut[0].bus.frame_end}, 32'd0);

        random_run(300);

        // Asynchronous reset mid-frame, away from any clock edge.
        wait_pix(10, 5);
        #1 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        #3 rst = 1'b0;
        check_release();

        random_run(1500);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
